// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller poll/decode path: FSM states,
// frame bit positions, decoded-button positions and host event layout.
package n64_pkg;

    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_DECODE = 2'd2,
        S_PUSH   = 2'd3
    } state_t;

    // Bit positions inside rx_data (LSB = first bit on the wire)
    localparam int FRM_A     = 0;
    localparam int FRM_B     = 1;
    localparam int FRM_Z     = 2;
    localparam int FRM_START = 3;
    localparam int FRM_UP    = 4;
    localparam int FRM_DOWN  = 5;
    localparam int FRM_LEFT  = 6;
    localparam int FRM_RIGHT = 7;
    localparam int FRM_RST   = 8;
    localparam int FRM_RSVD  = 9;
    localparam int FRM_L     = 10;
    localparam int FRM_R     = 11;
    localparam int FRM_CU    = 12;
    localparam int FRM_CD    = 13;
    localparam int FRM_CL    = 14;
    localparam int FRM_CR    = 15;
    localparam int FRM_X_LSB = 16;
    localparam int FRM_Y_LSB = 24;

    // Bit positions inside the decoded buttons vector
    localparam int NUM_BTN   = 14;
    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_Z     = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_L     = 8;
    localparam int BTN_R     = 9;
    localparam int BTN_CU    = 10;
    localparam int BTN_CD    = 11;
    localparam int BTN_CL    = 12;
    localparam int BTN_CR    = 13;

    // Host event layout
    localparam int EVT_X_LSB   = 0;
    localparam int EVT_Y_LSB   = 8;
    localparam int EVT_BTN_LSB = 16;
    localparam int EVT_RSVD    = 30;
    localparam int EVT_CONN    = 31;

    // Field order matches evt_data[29:0]
    typedef struct packed {
        logic [NUM_BTN-1:0] buttons;
        logic [7:0]         stick_y;
        logic [7:0]         stick_x;
    } pad_state_t;

    // Stick bytes arrive MSB first, so the LSB-first frame holds them reversed
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [FRAME_W-1:0] pack_evt(input logic conn, input pad_state_t s);
        return {conn, 1'b0, s};
    endfunction

endpackage

// File: rtl/n64_frame_decode.sv
// Combinational frame decoder: maps the raw 32-bit status frame onto
// buttons plus signed, dead-zoned stick axes.
module n64_frame_decode
    import n64_pkg::*;
#(
    parameter int DEADZONE = 8
) (
    input  logic [FRAME_W-1:0] rx_data,
    output pad_state_t         pad
);

    // Reset and reserved bits carry no host-visible state
    logic unused_frame_bits;
    assign unused_frame_bits = ^rx_data[FRM_RSVD:FRM_RST];

    // Magnitude taken at 9 bits so -128 becomes +128 instead of wrapping
    function automatic logic [7:0] dead_zone(input logic [7:0] v);
        logic [8:0] mag;
        mag = v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
        return (mag < 9'(DEADZONE)) ? 8'd0 : v;
    endfunction

    // Button remap and stick recovery
    always_comb begin
        pad = '0;
        pad.buttons[BTN_A]     = rx_data[FRM_A];
        pad.buttons[BTN_B]     = rx_data[FRM_B];
        pad.buttons[BTN_Z]     = rx_data[FRM_Z];
        pad.buttons[BTN_START] = rx_data[FRM_START];
        pad.buttons[BTN_UP]    = rx_data[FRM_UP];
        pad.buttons[BTN_DOWN]  = rx_data[FRM_DOWN];
        pad.buttons[BTN_LEFT]  = rx_data[FRM_LEFT];
        pad.buttons[BTN_RIGHT] = rx_data[FRM_RIGHT];
        pad.buttons[BTN_L]     = rx_data[FRM_L];
        pad.buttons[BTN_R]     = rx_data[FRM_R];
        pad.buttons[BTN_CU]    = rx_data[FRM_CU];
        pad.buttons[BTN_CD]    = rx_data[FRM_CD];
        pad.buttons[BTN_CL]    = rx_data[FRM_CL];
        pad.buttons[BTN_CR]    = rx_data[FRM_CR];
        pad.stick_x = dead_zone(bit_rev8(rx_data[FRM_X_LSB +: 8]));
        pad.stick_y = dead_zone(bit_rev8(rx_data[FRM_Y_LSB +: 8]));
    end

endmodule

// File: rtl/n64_poll_ctrl.sv
// N64 controller poll controller: paces polls to the receiver, supervises
// the response with a timeout, decodes frames and raises host events on change.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | waiting for a poll tick with enable set; issues go
//  S_WAIT   | waiting for rx_valid or timeout (timeout pulses rx_reset_req)
//  S_DECODE | registers decoded frame, marks link connected, compares
//  S_PUSH   | pushes a host event if state or link status changed
module n64_poll_ctrl
    import n64_pkg::*;
#(
    parameter int CLK_FREQ   = 30_000_000,
    parameter int POLL_HZ    = 100,
    parameter int TIMEOUT_US = 1000,
    parameter int MISS_LIMIT = 3,
    parameter int DEADZONE   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic               go,
    input  logic [FRAME_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_reset_req,
    output logic [FRAME_W-1:0] evt_data,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_overrun,
    output logic               connected
);

    localparam int POLL_TICKS = CLK_FREQ / POLL_HZ;
    localparam int TO_TICKS   = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int POLL_W     = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int TO_W       = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
    localparam int MISS_W     = $clog2(MISS_LIMIT + 1);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_TICKS - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TO_TICKS - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT_V = MISS_W'(MISS_LIMIT);

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_cnt_q;
    logic                poll_tick;
    logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d, miss_inc;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    pad_state_t          pad_dec;
    pad_state_t          dec_q, dec_d;
    pad_state_t          last_q, last_d;
    logic                changed_q, changed_d;
    logic                conn_q, conn_d;
    logic                go_d, req_d;
    logic                push;
    logic [FRAME_W-1:0]  push_data;

    n64_frame_decode #(
        .DEADZONE (DEADZONE)
    ) u_decode (
        .rx_data (frame_q),
        .pad     (pad_dec)
    );

    assign poll_tick = (poll_cnt_q == POLL_LAST);
    assign miss_inc  = (miss_cnt_q == MISS_LIMIT_V) ? miss_cnt_q : miss_cnt_q + MISS_W'(1);
    assign connected = conn_q;

    // Free-running poll timer; ticks that land outside S_IDLE are simply lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt_q <= '0;
        end else if (poll_tick) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + POLL_W'(1);
        end
    end

    // FSM state and transaction registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            frame_q      <= '0;
            dec_q        <= '0;
            last_q       <= '0;
            changed_q    <= 1'b0;
            conn_q       <= 1'b0;
            go           <= 1'b0;
            rx_reset_req <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            frame_q      <= frame_d;
            dec_q        <= dec_d;
            last_q       <= last_d;
            changed_q    <= changed_d;
            conn_q       <= conn_d;
            go           <= go_d;
            rx_reset_req <= req_d;
        end
    end

    // Next-state logic; a frame in the timeout cycle takes priority over the timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        miss_cnt_d = miss_cnt_q;
        frame_d    = frame_q;
        dec_d      = dec_q;
        last_d     = last_q;
        changed_d  = changed_q;
        conn_d     = conn_q;
        go_d       = 1'b0;
        req_d      = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (poll_tick && enable) begin
                    go_d       = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_valid) begin
                    frame_d    = rx_data;
                    miss_cnt_d = '0;
                    state_d    = S_DECODE;
                end else if (wait_cnt_q == TO_LAST) begin
                    req_d      = 1'b1;
                    miss_cnt_d = miss_inc;
                    state_d    = S_IDLE;
                    // Losing the link reports an all-zero pad once
                    if ((miss_inc == MISS_LIMIT_V) && conn_q) begin
                        conn_d    = 1'b0;
                        last_d    = '0;
                        push      = 1'b1;
                        push_data = pack_evt(1'b0, '0);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                dec_d     = pad_dec;
                conn_d    = 1'b1;
                changed_d = (pad_dec != last_q) || !conn_q;
                state_d   = S_PUSH;
            end
            S_PUSH: begin
                if (changed_q) begin
                    push      = 1'b1;
                    push_data = pack_evt(1'b1, dec_q);
                    last_d    = dec_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Host event register; a push that cannot be taken is dropped and flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_data    <= '0;
            evt_valid   <= 1'b0;
            evt_overrun <= 1'b0;
        end else if (push) begin
            if (!evt_valid || evt_ready) begin
                evt_data  <= push_data;
                evt_valid <= 1'b1;
            end else begin
                evt_overrun <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_n64_poll_ctrl.sv
// Self-checking bench for n64_poll_ctrl with a scoreboard of expected host events.
module tb_n64_poll_ctrl;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int POLL_HZ    = 1000;
    localparam int TIMEOUT_US = 100;
    localparam int MISS_LIMIT = 3;
    localparam int DEADZONE   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        go;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_reset_req;
    logic [31:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_overrun;
    logic        connected;

    n64_poll_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .POLL_HZ    (POLL_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .MISS_LIMIT (MISS_LIMIT),
        .DEADZONE   (DEADZONE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .go           (go),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_reset_req (rx_reset_req),
        .evt_data     (evt_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_overrun  (evt_overrun),
        .connected    (connected)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_evt  = 0;
    int          m_cnt  = 0;
    logic [31:0] sb[$];

    // Reference model state
    logic        m_conn = 1'b0;
    logic [29:0] m_last = '0;
    int          m_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Every accepted handshake must match the oldest expected event
    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            n_evt++;
            chk("evt_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) chk("evt_data", evt_data, sb.pop_front());
        end
    end

    function automatic logic [7:0] m_axis(input logic [7:0] b);
        logic [7:0] v;
        int         s;
        for (int i = 0; i < 8; i++) v[i] = b[7-i];
        s = int'($signed(v));
        if (s < 0) s = -s;
        return (s < DEADZONE) ? 8'h00 : v;
    endfunction

    function automatic logic [29:0] m_dec(input logic [31:0] f);
        return {f[15:10], f[7:0], m_axis(f[31:24]), m_axis(f[23:16])};
    endfunction

    task automatic wait_go(output int c);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (go) break;
        end
        chk("go_seen", 32'(go), 32'd1);
        c = cyc;
    endtask

    task automatic pulse_frame(input logic [31:0] f, input bit accepted);
        logic [29:0] d;
        d = m_dec(f);
        if ((d != m_last) || !m_conn) begin
            if (accepted) begin
                sb.push_back({1'b1, 1'b0, d});
                m_cnt++;
            end
            m_last = d;
        end
        m_conn = 1'b1;
        m_miss = 0;
        @(posedge clk); #1;
        rx_data  = f;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] f, input bit accepted);
        int c;
        wait_go(c);
        pulse_frame(f, accepted);
    endtask

    task automatic do_timeout(output int c0);
        wait_go(c0);
        if (m_miss < MISS_LIMIT) m_miss++;
        if ((m_miss == MISS_LIMIT) && m_conn) begin
            sb.push_back(32'h0);
            m_cnt++;
            m_conn = 1'b0;
            m_last = '0;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_reset_req) break;
        end
        chk("req_seen", 32'(rx_reset_req), 32'd1);
        chk("req_delay", 32'(cyc - c0), 32'd100);
        @(negedge clk);
        chk("req_pulse", 32'(rx_reset_req), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_go"},       32'(go),           32'd0);
        chk({tag, "_req"},      32'(rx_reset_req), 32'd0);
        chk({tag, "_evalid"},   32'(evt_valid),    32'd0);
        chk({tag, "_edata"},    evt_data,          32'd0);
        chk({tag, "_overrun"},  32'(evt_overrun),  32'd0);
        chk({tag, "_conn"},     32'(connected),    32'd0);
    endtask

    // Frames for the decode sweep and the evt_data held after each
    logic [31:0] frm_tab [7] = '{
        {8'h00, 8'h4C, 16'h0001},   // X +50
        {8'h00, 8'hA0, 16'h0001},   // X +5 -> dead zone
        {8'h00, 8'h01, 16'h0001},   // X -128 kept
        {8'hDF, 8'h01, 16'h0001},   // Y -5 -> dead zone, no change
        {8'h1F, 8'hE0, 16'h0004},   // Y -8 kept, X +7 -> 0, Z
        {8'h00, 8'h10, 16'hFD00},   // X +8 kept, upper buttons + rst bit
        {8'h00, 8'h10, 16'hFE00}    // rsvd instead of rst: same state
    };
    logic [31:0] hold_tab [7] = '{
        32'h8001_0032, 32'h8001_0000, 32'h8001_0080, 32'h8001_0080,
        32'h8004_F800, 32'hBF00_0008, 32'hBF00_0008
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, g2, rel, c, evt_before;
        reset_n   = 1'b0;
        enable    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // 1: no controller -> periodic go and receiver resets, no events
        do_timeout(g0);
        do_timeout(g1);
        do_timeout(g2);
        chk("go_period1", 32'(g1 - g0), 32'd1000);
        chk("go_period2", 32'(g2 - g1), 32'd1000);
        chk("t1_conn", 32'(connected), 32'd0);
        chk("t1_no_evt", 32'(n_evt), 32'd0);

        // 2: first frame connects; identical frame is silent
        send_frame(32'h0000_0001, 1'b1);
        chk("t2_conn", 32'(connected), 32'd1);
        chk("t2_evt_a", evt_data, 32'h8001_0000);
        send_frame(32'h0000_0001, 1'b1);
        chk("t2_count", 32'(n_evt), 32'(m_cnt));

        // 3: decode sweep, stick bit order and dead-zone edges
        for (int i = 0; i < 7; i++) begin
            send_frame(frm_tab[i], 1'b1);
            chk($sformatf("t3_hold%0d", i), evt_data, hold_tab[i]);
        end
        chk("t3_count", 32'(n_evt), 32'(m_cnt));

        // 4: miss counting, reset by a frame, drop after the limit
        do_timeout(c);
        do_timeout(c);
        send_frame(frm_tab[6], 1'b1);
        do_timeout(c);
        do_timeout(c);
        chk("t4_miss_reset", 32'(connected), 32'd1);
        do_timeout(c);
        chk("t4_conn", 32'(connected), 32'd0);
        chk("t4_evt_zero", evt_data, 32'h0);
        chk("t4_count", 32'(n_evt), 32'(m_cnt));

        // 5: back-pressure holds the first event and flags the dropped one
        @(posedge clk); #1;
        evt_ready = 1'b0;
        send_frame(32'h0000_0002, 1'b1);
        chk("t5_valid", 32'(evt_valid), 32'd1);
        send_frame(32'h0000_0010, 1'b0);
        chk("t5_held_valid", 32'(evt_valid), 32'd1);
        chk("t5_held_data", evt_data, 32'h8002_0000);
        chk("t5_overrun", 32'(evt_overrun), 32'd1);
        @(posedge clk); #1;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_valid_drop", 32'(evt_valid), 32'd0);
        chk("t5_count", 32'(n_evt), 32'(m_cnt));

        // 6: reset mid-wait, late rx_valid ignored, next go only on a tick
        wait_go(c);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("t6_rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        rel = cyc;
        m_conn = 1'b0;
        m_last = '0;
        m_miss = 0;
        evt_before = n_evt;
        repeat (4) @(posedge clk);
        #1;
        rx_data  = 32'h0000_0001;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_evt", 32'(n_evt - evt_before), 32'd0);
        chk("t6_conn", 32'(connected), 32'd0);
        chk("t6_evalid", 32'(evt_valid), 32'd0);
        wait_go(c);
        chk("t6_go_tick", ((c - rel) >= 990 && (c - rel) <= 1010) ? 32'd1 : 32'd0, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
